// File: rtl/spi_register_slave.sv
// SPI mode-0 register slave: one 8-bit command (R/W + address) followed by one 16-bit data word.
// All SPI pins are oversampled in the clk domain, so sclk must stay well below clk.
module spi_register_slave #(
    parameter int SIZE_COMMAND    = 8,
    parameter int SIZE_REGISTER   = 16,
    parameter int NUMBER_REGISTER = 128,
    localparam int ADDR_W         = $clog2(NUMBER_REGISTER)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     spi_sclk,
    input  logic                     spi_cs_n,
    input  logic                     spi_mosi,
    output logic                     spi_miso,
    output logic                     spi_miso_oe,
    output logic [ADDR_W-1:0]        reg_addr,
    output logic                     reg_wr_en,
    output logic [SIZE_REGISTER-1:0] reg_wr_data,
    output logic                     reg_rd_en,
    input  logic [SIZE_REGISTER-1:0] reg_rd_data,
    output logic                     frame_error,
    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMMAND = 2'd1,
        DATA    = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int         FRAME_EDGES     = SIZE_COMMAND + SIZE_REGISTER;
    localparam logic [5:0] LAST_CMD_EDGE   = 6'(SIZE_COMMAND - 1);
    localparam logic [5:0] LAST_FRAME_EDGE = 6'(FRAME_EDGES - 1);

    // Handshake with the register file: reg_wr_en and reg_rd_en are single-cycle
    // strobes with no back-pressure; reg_rd_data must be valid exactly one clk
    // after reg_rd_en and is sampled only in that cycle.

    state_t state_q, state_d;

    logic [2:0]               sclk_sync;
    logic [2:0]               cs_sync;
    logic [1:0]               mosi_sync;
    logic [1:0]               settle_cnt;
    logic                     cs_armed;
    logic [5:0]               bit_cnt;
    logic [SIZE_COMMAND-2:0]  cmd_shift;
    logic [SIZE_REGISTER-2:0] rx_shift;
    logic [SIZE_REGISTER-1:0] tx_shift;
    logic                     is_read;
    logic                     rd_capture;

    logic                     sclk_rise;
    logic                     sclk_fall;
    logic                     cs_rise;
    logic                     cs_fall;
    logic                     mosi_bit;
    logic [SIZE_COMMAND-1:0]  cmd_word;
    logic [SIZE_REGISTER-1:0] rx_word;
    logic                     frame_start;
    logic                     abort;
    logic                     cmd_done;
    logic                     data_done;

    assign dbg_state = state_q;

    // Two synchronizer flops per pin plus a third for edge detection on sclk and cs_n.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync  <= 3'b000;
            cs_sync    <= 3'b111;
            mosi_sync  <= 2'b00;
            settle_cnt <= 2'd0;
            cs_armed   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], spi_sclk};
            cs_sync   <= {cs_sync[1:0], spi_cs_n};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            if (settle_cnt != 2'd3) begin
                settle_cnt <= settle_cnt + 2'd1;
            end
            // Once the chain holds real pin samples, a frame may start only after
            // cs_n has been seen high; this drops the tail of a frame cut by reset.
            if (settle_cnt == 2'd3 && cs_sync[1] && cs_sync[2]) begin
                cs_armed <= 1'b1;
            end
        end
    end

    always_comb begin
        sclk_rise   = sclk_sync[1] & ~sclk_sync[2];
        sclk_fall   = ~sclk_sync[1] & sclk_sync[2];
        cs_rise     = cs_sync[1] & ~cs_sync[2];
        cs_fall     = ~cs_sync[1] & cs_sync[2];
        mosi_bit    = mosi_sync[1];
        cmd_word    = {cmd_shift, mosi_bit};
        rx_word     = {rx_shift, mosi_bit};
        frame_start = (state_q == IDLE) && cs_fall && cs_armed;
        abort       = ((state_q == COMMAND) || (state_q == DATA)) && cs_rise;
        cmd_done    = (state_q == COMMAND) && sclk_rise && !cs_rise && (bit_cnt == LAST_CMD_EDGE);
        data_done   = (state_q == DATA) && sclk_rise && !cs_rise && (bit_cnt == LAST_FRAME_EDGE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = COMMAND;
                end
            end
            COMMAND: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cmd_done) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (data_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt     <= 6'd0;
            cmd_shift   <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            is_read     <= 1'b0;
            rd_capture  <= 1'b0;
            reg_addr    <= '0;
            reg_wr_en   <= 1'b0;
            reg_wr_data <= '0;
            reg_rd_en   <= 1'b0;
            frame_error <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
        end else begin
            reg_wr_en   <= 1'b0;
            reg_rd_en   <= 1'b0;
            frame_error <= 1'b0;
            rd_capture  <= reg_rd_en;

            // The read word lands well before the first data falling edge,
            // because sclk high time covers the rd_en to capture latency.
            if (rd_capture) begin
                tx_shift <= reg_rd_data;
            end else if ((state_q == DATA) && sclk_fall && is_read && !cs_rise) begin
                tx_shift <= {tx_shift[SIZE_REGISTER-2:0], 1'b0};
            end

            case (state_q)
                IDLE: begin
                    spi_miso    <= 1'b0;
                    spi_miso_oe <= 1'b0;
                    if (frame_start) begin
                        bit_cnt   <= 6'd0;
                        cmd_shift <= '0;
                        rx_shift  <= '0;
                        is_read   <= 1'b0;
                    end
                end
                COMMAND: begin
                    if (abort) begin
                        frame_error <= 1'b1;
                    end else if (sclk_rise) begin
                        cmd_shift <= cmd_word[SIZE_COMMAND-2:0];
                        bit_cnt   <= bit_cnt + 6'd1;
                        if (cmd_done) begin
                            reg_addr  <= cmd_word[ADDR_W-1:0];
                            is_read   <= cmd_word[SIZE_COMMAND-1];
                            reg_rd_en <= cmd_word[SIZE_COMMAND-1];
                        end
                    end
                end
                DATA: begin
                    if (abort) begin
                        frame_error <= 1'b1;
                        spi_miso    <= 1'b0;
                        spi_miso_oe <= 1'b0;
                    end else if (sclk_rise) begin
                        rx_shift <= rx_word[SIZE_REGISTER-2:0];
                        bit_cnt  <= bit_cnt + 6'd1;
                        if (data_done) begin
                            reg_wr_en   <= !is_read;
                            spi_miso    <= 1'b0;
                            spi_miso_oe <= 1'b0;
                            if (!is_read) begin
                                reg_wr_data <= rx_word;
                            end
                        end
                    end else if (sclk_fall && is_read) begin
                        spi_miso    <= tx_shift[SIZE_REGISTER-1];
                        spi_miso_oe <= 1'b1;
                    end
                end
                DONE: begin
                    spi_miso    <= 1'b0;
                    spi_miso_oe <= 1'b0;
                end
                default: begin
                    spi_miso    <= 1'b0;
                    spi_miso_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_register_slave.sv
// Directed bench for spi_register_slave: frames are driven pin by pin, expected strobes
// and MISO words are queued up front and matched by an independent monitor.
module tb_spi_register_slave;

    localparam int EV_W = 25;
    localparam logic [1:0] EV_WR  = 2'd0;
    localparam logic [1:0] EV_RD  = 2'd1;
    localparam logic [1:0] EV_ERR = 2'd2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [6:0]  reg_addr;
    logic        reg_wr_en;
    logic [15:0] reg_wr_data;
    logic        reg_rd_en;
    logic [15:0] reg_rd_data;
    logic        frame_error;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [EV_W-1:0] exp_q[$];
    logic [15:0]     miso_exp_q[$];
    logic [15:0]     miso_obs_q[$];
    logic [15:0]     rd_value = 16'h0000;
    logic            cur_read = 1'b0;

    always #5 clk = ~clk;

    spi_register_slave dut (
        .clk        (clk),
        .reset      (reset),
        .spi_sclk   (spi_sclk),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .reg_addr   (reg_addr),
        .reg_wr_en  (reg_wr_en),
        .reg_wr_data(reg_wr_data),
        .reg_rd_en  (reg_rd_en),
        .reg_rd_data(reg_rd_data),
        .frame_error(frame_error),
        .dbg_state  (dbg_state)
    );

    // Register-file responder: read data is valid only in the cycle one clk after reg_rd_en.
    always @(posedge clk) begin
        reg_rd_data <= reg_rd_en ? rd_value : 16'hDEAD;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_strobe(input string name, input logic [EV_W-1:0] act);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: unexpected event %h, expected none at %0t", name, act, $time);
        end else begin
            check(name, 32'(act), 32'(exp_q.pop_front()));
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        logic [15:0] obs;
        check("miso_gated", {31'b0, spi_miso & ~spi_miso_oe}, 32'd0);
        check("oe_on_write", {31'b0, spi_miso_oe & ~cur_read}, 32'd0);
        if (reg_wr_en)   expect_strobe("wr_strobe", {EV_WR, reg_addr, reg_wr_data});
        if (reg_rd_en)   expect_strobe("rd_strobe", {EV_RD, reg_addr, 16'h0000});
        if (frame_error) expect_strobe("frame_error", {EV_ERR, 7'h00, 16'h0000});
        if (miso_obs_q.size() > 0) begin
            obs = miso_obs_q.pop_front();
            if (miso_exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL miso_word: got %h, expected none", obs);
            end else begin
                check("miso_word", 32'(obs), 32'(miso_exp_q.pop_front()));
            end
        end
    end

    // Drives one frame: n_edges real sclk cycles plus 'extra' trailing ones, optional
    // reset after rising edge reset_edge (0 = none), then cs_n high for 'gap' clk.
    task automatic spi_frame(input logic [7:0] cmd, input logic [15:0] data, input int n_edges,
                             input int extra, input int reset_edge, input int gap);
        logic [23:0] bits;
        logic [31:0] samples;
        logic [15:0] obs;
        bits     = {cmd, data};
        samples  = '0;
        cur_read = cmd[7];
        spi_sclk = 1'b0;
        spi_cs_n = 1'b0;
        for (int e = 0; e < n_edges + extra; e++) begin
            spi_mosi = (e < 24) ? bits[23-e] : 1'b0;
            repeat (4) @(negedge clk);
            spi_sclk   = 1'b1;
            samples[e] = spi_miso;
            if (e + 1 == reset_edge) begin
                reset = 1'b1;
                repeat (2) @(negedge clk);
                reset = 1'b0;
                check("rst_mid_wr_en", {31'b0, reg_wr_en}, 32'd0);
                check("rst_mid_rd_en", {31'b0, reg_rd_en}, 32'd0);
                check("rst_mid_ferr", {31'b0, frame_error}, 32'd0);
                check("rst_mid_miso", {30'b0, spi_miso, spi_miso_oe}, 32'd0);
                check("rst_mid_addr", {25'b0, reg_addr}, 32'd0);
                check("rst_mid_state", {30'b0, dbg_state}, 32'd0);
            end
            repeat (4) @(negedge clk);
            spi_sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        obs = '0;
        if (cmd[7] && n_edges == 24 && reset_edge == 0) begin
            for (int k = 0; k < 16; k++) obs[15-k] = samples[8+k];
        end else begin
            obs = {15'b0, |samples};
        end
        miso_obs_q.push_back(obs);
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_wr_en", {31'b0, reg_wr_en}, 32'd0);
        check("reset_rd_en", {31'b0, reg_rd_en}, 32'd0);
        check("reset_ferr", {31'b0, frame_error}, 32'd0);
        check("reset_miso", {30'b0, spi_miso, spi_miso_oe}, 32'd0);
        check("reset_addr", {25'b0, reg_addr}, 32'd0);
        check("reset_wr_data", {16'b0, reg_wr_data}, 32'd0);
        check("reset_state", {30'b0, dbg_state}, 32'd0);
        reset = 1'b0;
        repeat (8) @(negedge clk);

        // Plain write
        exp_q.push_back({EV_WR, 7'h05, 16'hA5C3});
        miso_exp_q.push_back(16'h0000);
        spi_frame(8'h05, 16'hA5C3, 24, 0, 0, 8);

        // Read: address 0x05, register returns 0x1234
        rd_value = 16'h1234;
        exp_q.push_back({EV_RD, 7'h05, 16'h0000});
        miso_exp_q.push_back(16'h1234);
        spi_frame(8'h85, 16'h0000, 24, 0, 0, 8);

        // Aborted write after 20 edges, then a normal write
        exp_q.push_back({EV_ERR, 7'h00, 16'h0000});
        miso_exp_q.push_back(16'h0000);
        spi_frame(8'h22, 16'h5555, 20, 0, 0, 8);
        exp_q.push_back({EV_WR, 7'h7F, 16'hFFFF});
        miso_exp_q.push_back(16'h0000);
        spi_frame(8'h7F, 16'hFFFF, 24, 0, 0, 8);

        // Extra sclk cycles in DONE
        exp_q.push_back({EV_WR, 7'h10, 16'h0001});
        miso_exp_q.push_back(16'h0000);
        spi_frame(8'h10, 16'h0001, 24, 4, 0, 8);

        // Reset during data bit 10, then a normal write
        miso_exp_q.push_back(16'h0000);
        spi_frame(8'h3C, 16'h0F0F, 24, 0, 18, 8);
        exp_q.push_back({EV_WR, 7'h05, 16'hA5C3});
        miso_exp_q.push_back(16'h0000);
        spi_frame(8'h05, 16'hA5C3, 24, 0, 0, 8);

        // Back-to-back frames, cs_n high 4 clk between
        exp_q.push_back({EV_WR, 7'h33, 16'hBEEF});
        miso_exp_q.push_back(16'h0000);
        spi_frame(8'h33, 16'hBEEF, 24, 0, 0, 4);
        rd_value = 16'hCAFE;
        exp_q.push_back({EV_RD, 7'h44, 16'h0000});
        miso_exp_q.push_back(16'hCAFE);
        spi_frame(8'hC4, 16'h0000, 24, 0, 0, 4);
        exp_q.push_back({EV_WR, 7'h01, 16'h8001});
        miso_exp_q.push_back(16'h0000);
        spi_frame(8'h01, 16'h8001, 24, 0, 0, 8);

        for (int i = 0; i < 100 && (exp_q.size() != 0 || miso_obs_q.size() != 0); i++) begin
            @(negedge clk);
        end
        repeat (20) @(negedge clk);
        check("strobes_drained", 32'(exp_q.size()), 32'd0);
        check("miso_drained", 32'(miso_exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_register_slave.md
SPI_REGISTER_SLAVE -- requirements
Module: spi_register_slave

Interface
REQ-001 Parameter SIZE_COMMAND, default 8: command byte width; bit 7 selects R/W, bits 6:0 hold the address.
REQ-002 Parameter SIZE_REGISTER, default 16: register data width.
REQ-003 Parameter NUMBER_REGISTER, default 128: addressable registers; address width is log2(NUMBER_REGISTER) = 7.
REQ-004 Port clk, input, 1: single system clock; all logic is on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port spi_sclk, input, 1: SPI clock from the master; asynchronous to clk.
REQ-007 Port spi_cs_n, input, 1: chip select, active low; asynchronous.
REQ-008 Port spi_mosi, input, 1: serial data from the master; asynchronous.
REQ-009 Port spi_miso, output, 1: serial data to the master.
REQ-010 Port spi_miso_oe, output, 1: MISO output enable; high only while a read data phase is active.
REQ-011 Port reg_addr, output, 7: register address latched from the command byte.
REQ-012 Port reg_wr_en, output, 1: one-cycle write strobe.
REQ-013 Port reg_wr_data, output, 16: write data; valid while reg_wr_en is high.
REQ-014 Port reg_rd_en, output, 1: one-cycle read request.
REQ-015 Port reg_rd_data, input, 16: read data; valid exactly 1 clk after reg_rd_en.
REQ-016 Port frame_error, output, 1: one-cycle pulse on an aborted frame.

Function
REQ-017 spi_sclk, spi_cs_n and spi_mosi shall each pass a 2-flop synchronizer.
REQ-018 Edge detect shall use a third flop; a sclk rising or falling edge, or a cs_n change, is detected 3 clk after the pin toggles.
REQ-019 SPI mode 0: MOSI sampled on detected sclk rising edges; MISO updated on detected falling edges; MSB first.
REQ-020 Frame format: 8-bit command followed by 16-bit data, 24 sclk rising edges in total.
REQ-021 Timing contract: sclk high time and low time shall each be at least 4 clk.
REQ-022 FSM states: IDLE, COMMAND, DATA, DONE.
- IDLE -> COMMAND on detected cs_n falling; bit counter (6 bits) cleared.
- COMMAND -> DATA after the 8th rising edge.
- DATA -> DONE after the 24th rising edge.
- DONE -> IDLE on detected cs_n rising.
REQ-023 At the 8th rising edge, reg_addr shall latch command bits 6:0.
REQ-024 If command bit 7 = 1 (read), reg_rd_en shall pulse 1 clk after that edge detection.
REQ-025 reg_rd_data shall be captured into the transmit shift register 1 clk after reg_rd_en.
REQ-026 Read data phase: spi_miso_oe shall be 1 from the 8th detected falling edge until the frame ends.
REQ-027 spi_miso shall drive transmit bit 15 at the 8th falling edge, then shift one bit per subsequent falling edge.
REQ-028 If command bit 7 = 0 (write), the 16 data bits shall shift into the receive register.
REQ-029 For a write, reg_wr_en shall pulse 1 clk after the 24th rising edge detection, with reg_wr_data = the received word.
REQ-030 A read frame shall never assert reg_wr_en.
REQ-031 spi_miso shall be 0 whenever spi_miso_oe = 0.
REQ-032 spi_miso shall be 0 in the COMMAND state.
REQ-033 spi_miso shall be 0 in the DONE state.
REQ-034 In DONE, extra sclk edges shall be ignored: no strobes, counter held.
REQ-035 A cs_n rising edge in COMMAND or DATA shall abort the frame: no reg_wr_en, frame_error pulses 1 clk, FSM -> IDLE.
REQ-036 A reg_rd_en already issued before an abort stands; only the write is suppressed.
REQ-037 A cs_n falling edge detected in the same clk as an abort cannot occur (same signal); a new frame starts only from IDLE.
REQ-038 Sclk edges in IDLE shall be ignored.

Reset
REQ-039 On reset: FSM = IDLE; counter, shift registers and reg_addr = 0.
REQ-040 On reset: reg_wr_en, reg_rd_en, frame_error, spi_miso and spi_miso_oe = 0.
REQ-041 Synchronizer flops shall reset to idle line levels: sclk = 0, cs_n = 1, mosi = 0.
REQ-042 A reset mid-frame shall discard the frame and produce no strobe and no frame_error.
REQ-043 The remainder of a frame interrupted by reset is ignored until cs_n is next seen rising then falling.

Verification
REQ-044 Write frame cmd 0x05, data 0xA5C3, sclk = clk/8 -> one reg_wr_en pulse, reg_addr = 0x05, reg_wr_data = 0xA5C3, frame_error = 0.
REQ-045 Read frame cmd 0x85, reg_rd_data = 0x1234 driven 1 clk after reg_rd_en -> reg_addr = 0x05, MISO bits sampled on rising edges 9-24 = 0x1234, no reg_wr_en.
REQ-046 Write frame with cs_n raised after 20 rising edges -> no reg_wr_en, frame_error one pulse, next full frame cmd 0x7F, data 0xFFFF writes normally.
REQ-047 Write frame cmd 0x10, data 0x0001 followed by 4 extra sclk cycles before cs_n rises -> exactly one reg_wr_en, data 0x0001, MISO stays 0.
REQ-048 Assert reset during data bit 10 of a write frame -> all outputs 0, no strobe; the following complete frame behaves per REQ-044.
REQ-049 Back-to-back frames with cs_n high for 4 clk between them -> both frames' strobes occur with correct addresses and data.
